// File: rtl/instr_ram_arbiter_pkg.sv
// Shared definitions for the instruction RAM arbiter and its neighbours
// (fetch stage, boot loader).
package instr_ram_arbiter_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 10;
  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned STARVE_CNT_WIDTH = 4;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/instr_ram_arbiter_if.sv
// Fetch, loader and RAM-macro signals seen by the instruction RAM arbiter.
// slave = arbiter side, master = requesters/RAM side.
interface instr_ram_arbiter_if
  import instr_ram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
);

  logic                  fetch_req;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic                  fetch_gnt;
  logic                  fetch_valid;
  logic [DATA_WIDTH-1:0] fetch_data;

  logic                  load_req;
  logic [ADDR_WIDTH-1:0] load_addr;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_done;
  logic                  load_gnt;

  logic                  cpu_hold;

  logic                  ram_en;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;

  modport slave (
    input  fetch_req, fetch_addr, load_req, load_addr, load_data, load_done,
           ram_rdata,
    output fetch_gnt, fetch_valid, fetch_data, load_gnt, cpu_hold,
           ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output fetch_req, fetch_addr, load_req, load_addr, load_data, load_done,
           ram_rdata,
    input  fetch_gnt, fetch_valid, fetch_data, load_gnt, cpu_hold,
           ram_en, ram_we, ram_addr, ram_wdata
  );

endinterface

// File: rtl/instr_ram_arbiter_prio.sv
// Run-mode selector: fetch wins over load unless force_load pushes a
// pending load through. At most one grant is ever asserted.
module instr_ram_prio (
  input  logic fetch_req,
  input  logic load_req,
  input  logic force_load,
  output logic fetch_gnt,
  output logic load_gnt
);

  always_comb begin
    fetch_gnt = 1'b0;
    load_gnt  = 1'b0;
    if (load_req && (force_load || !fetch_req)) begin
      load_gnt = 1'b1;
    end else if (fetch_req) begin
      fetch_gnt = 1'b1;
    end
  end

endmodule

// File: rtl/instr_ram_arbiter.sv
// Shares the single-port instruction RAM between boot loader writes and
// fetch reads; holds the CPU during BOOT, fetch-priority with anti-starvation in RUN.
module instr_ram_arbiter
  import instr_ram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  instr_ram_arbiter_if.slave bus
);

  localparam logic [STARVE_CNT_WIDTH-1:0] LIMIT = STARVE_CNT_WIDTH'(STARVE_LIMIT);

  arb_state_t                  state, state_nxt;
  logic [STARVE_CNT_WIDTH-1:0] starve_cnt;
  logic                        fetch_gnt, load_gnt;
  logic                        prio_fetch_gnt, prio_load_gnt;
  logic                        fetch_valid;

  instr_ram_prio u_prio (
    .fetch_req  (bus.fetch_req),
    .load_req   (bus.load_req),
    .force_load (starve_cnt == LIMIT),
    .fetch_gnt  (prio_fetch_gnt),
    .load_gnt   (prio_load_gnt)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  // Grants are gated by reset so nothing reaches the RAM while it is asserted.
  always_comb begin
    state_nxt = state;
    fetch_gnt = 1'b0;
    load_gnt  = 1'b0;
    if (reset) begin
      unique case (state)
        BOOT: begin
          load_gnt = bus.load_req;
          if (bus.load_done) begin
            state_nxt = RUN;
          end
        end
        RUN: begin
          fetch_gnt = prio_fetch_gnt;
          load_gnt  = prio_load_gnt;
        end
        default: state_nxt = BOOT;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (state != RUN || load_gnt || !bus.load_req) begin
      starve_cnt <= '0;
    end else if (fetch_gnt && starve_cnt < LIMIT) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_valid <= 1'b0;
    end else begin
      fetch_valid <= fetch_gnt;
    end
  end

  always_comb begin
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    if (load_gnt) begin
      bus.ram_addr  = bus.load_addr;
      bus.ram_wdata = bus.load_data;
    end else if (fetch_gnt) begin
      bus.ram_addr  = bus.fetch_addr;
    end
  end

  assign bus.ram_en      = fetch_gnt | load_gnt;
  assign bus.ram_we      = load_gnt;
  assign bus.fetch_gnt   = fetch_gnt;
  assign bus.load_gnt    = load_gnt;
  assign bus.fetch_valid = fetch_valid;
  assign bus.fetch_data  = bus.ram_rdata;
  assign bus.cpu_hold    = (state == BOOT);

endmodule

// File: tb/tb_instr_ram_arbiter.sv
// Directed bench for instr_ram_arbiter with a 1-cycle-latency RAM model.
module tb_instr_ram_arbiter;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  instr_ram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  instr_ram_arbiter #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .STARVE_LIMIT (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clock) begin
    if (bus.ram_en && bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    if (bus.ram_en && !bus.ram_we) bus.ram_rdata <= mem[bus.ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic freq, input logic [AW-1:0] faddr,
                       input logic lreq, input logic [AW-1:0] laddr,
                       input logic [DW-1:0] ldata, input logic ldone);
    bus.fetch_req  = freq;
    bus.fetch_addr = faddr;
    bus.load_req   = lreq;
    bus.load_addr  = laddr;
    bus.load_data  = ldata;
    bus.load_done  = ldone;
  endtask

  logic [DW-1:0] image [0:5];

  initial begin
    image[0] = 32'h6C000000; image[1] = 32'h6840002D; image[2] = 32'h68400001;
    image[3] = 32'h68600010; image[4] = 32'h7C000002; image[5] = 32'h48000000;
    bus.ram_rdata = '0;

    // Reset asserted with both requests pending: nothing granted
    drive(1'b1, 10'd1, 1'b1, 10'd9, 32'hDEADBEEF, 1'b0);
    #2;
    chk("rst_cpu_hold", 32'(bus.cpu_hold), 32'd1);
    chk("rst_fetch_valid", 32'(bus.fetch_valid), 32'd0);
    chk("rst_load_gnt", 32'(bus.load_gnt), 32'd0);
    chk("rst_fetch_gnt", 32'(bus.fetch_gnt), 32'd0);
    chk("rst_ram_en", 32'(bus.ram_en), 32'd0);
    chk("rst_ram_we", 32'(bus.ram_we), 32'd0);

    // BOOT image load; load_done coincides with the last write
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i != 0) @(negedge clock);
      drive(1'b1, 10'd1, 1'b1, AW'(i), image[i], i == 5);
      #1;
      chk($sformatf("boot_load_gnt%0d", i), 32'(bus.load_gnt), 32'd1);
      chk($sformatf("boot_fetch_gnt%0d", i), 32'(bus.fetch_gnt), 32'd0);
      chk($sformatf("boot_hold%0d", i), 32'(bus.cpu_hold), 32'd1);
      chk($sformatf("boot_we%0d", i), 32'(bus.ram_we), 32'd1);
      chk($sformatf("boot_addr%0d", i), 32'(bus.ram_addr), 32'(i));
      chk($sformatf("boot_wdata%0d", i), bus.ram_wdata, image[i]);
    end

    // RUN entered, idle bus
    @(negedge clock);
    drive(1'b0, 10'd0, 1'b0, 10'd0, 32'h0, 1'b0);
    #1;
    chk("run_hold", 32'(bus.cpu_hold), 32'd0);
    chk("run_fetch_valid_idle", 32'(bus.fetch_valid), 32'd0);
    chk("idle_ram_en", 32'(bus.ram_en), 32'd0);
    chk("idle_ram_addr", 32'(bus.ram_addr), 32'd0);
    chk("idle_ram_wdata", bus.ram_wdata, 32'd0);

    // Continuous fetch of addr 1
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      drive(1'b1, 10'd1, 1'b0, 10'd0, 32'h0, 1'b0);
      #1;
      chk($sformatf("fetch_gnt%0d", k), 32'(bus.fetch_gnt), 32'd1);
      chk($sformatf("fetch_we%0d", k), 32'(bus.ram_we), 32'd0);
      chk($sformatf("fetch_addr%0d", k), 32'(bus.ram_addr), 32'd1);
      chk($sformatf("fetch_valid%0d", k), 32'(bus.fetch_valid), (k == 0) ? 32'd0 : 32'd1);
      if (k != 0) chk($sformatf("fetch_data%0d", k), bus.fetch_data, 32'h6840002D);
    end
    @(negedge clock);
    drive(1'b0, 10'd0, 1'b0, 10'd0, 32'h0, 1'b0);
    #1;
    chk("fetch_tail_valid", 32'(bus.fetch_valid), 32'd1);
    chk("fetch_tail_data", bus.fetch_data, 32'h6840002D);
    chk("fetch_tail_gnt", 32'(bus.fetch_gnt), 32'd0);
    @(negedge clock);
    #1;
    chk("fetch_valid_drop", 32'(bus.fetch_valid), 32'd0);

    // Contention: 4 fetches then 1 forced load, repeating
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      drive(1'b1, 10'd2, 1'b1, 10'd7, 32'hA5A5A5A5, 1'b0);
      #1;
      chk($sformatf("starve_fetch%0d", k), 32'(bus.fetch_gnt), (k % 5 == 4) ? 32'd0 : 32'd1);
      chk($sformatf("starve_load%0d", k), 32'(bus.load_gnt), (k % 5 == 4) ? 32'd1 : 32'd0);
      chk($sformatf("starve_onehot%0d", k), 32'(bus.fetch_gnt & bus.load_gnt), 32'd0);
    end

    // Write then immediate read-back of addr 3
    @(negedge clock);
    drive(1'b0, 10'd0, 1'b1, 10'd3, 32'h90620000, 1'b0);
    #1;
    chk("wr3_load_gnt", 32'(bus.load_gnt), 32'd1);
    chk("wr3_ram_wdata", bus.ram_wdata, 32'h90620000);
    @(negedge clock);
    drive(1'b1, 10'd3, 1'b0, 10'd0, 32'h0, 1'b0);
    #1;
    chk("rd3_fetch_gnt", 32'(bus.fetch_gnt), 32'd1);
    @(negedge clock);
    drive(1'b0, 10'd0, 1'b0, 10'd0, 32'h0, 1'b0);
    #1;
    chk("rd3_valid", 32'(bus.fetch_valid), 32'd1);
    chk("rd3_data", bus.fetch_data, 32'h90620000);

    // load_done in RUN is ignored
    @(negedge clock);
    drive(1'b0, 10'd0, 1'b0, 10'd0, 32'h0, 1'b1);
    @(negedge clock);
    drive(1'b1, 10'd0, 1'b0, 10'd0, 32'h0, 1'b0);
    #1;
    chk("run_done_hold", 32'(bus.cpu_hold), 32'd0);
    chk("run_done_fetch_gnt", 32'(bus.fetch_gnt), 32'd1);

    // Reset the cycle after a fetch grant
    @(negedge clock);
    drive(1'b1, 10'd1, 1'b0, 10'd0, 32'h0, 1'b0);
    #1;
    chk("pre_rst_fetch_gnt", 32'(bus.fetch_gnt), 32'd1);
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.fetch_valid), 32'd0);
    chk("mid_rst_hold", 32'(bus.cpu_hold), 32'd1);
    chk("mid_rst_fetch_gnt", 32'(bus.fetch_gnt), 32'd0);
    chk("mid_rst_ram_en", 32'(bus.ram_en), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    drive(1'b1, 10'd1, 1'b1, 10'd4, 32'h12345678, 1'b0);
    #1;
    chk("post_rst_hold", 32'(bus.cpu_hold), 32'd1);
    chk("post_rst_fetch_gnt", 32'(bus.fetch_gnt), 32'd0);
    chk("post_rst_load_gnt", 32'(bus.load_gnt), 32'd1);
    chk("post_rst_valid", 32'(bus.fetch_valid), 32'd0);

    @(negedge clock);
    drive(1'b0, 10'd0, 1'b0, 10'd0, 32'h0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_ram_arbiter.md
# instr_ram_arbiter

Sequences and shares the single-port instruction RAM between the boot loader (writes) and the fetch stage (reads). After reset it holds the CPU while the loader fills the RAM, then switches to run mode. In run mode fetches have priority, and an anti-starvation counter guarantees late loader writes eventually complete. Sits between the fetch stage/loader and the instruction RAM macro, which has 1-cycle registered read latency.

## Interface
- ADDR_WIDTH, 10, instruction RAM word-address width
- DATA_WIDTH, 32, instruction word width
- STARVE_LIMIT, 4, run-mode cycles a pending load may be refused before it is forced through (1..15)

- clock  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low
- fetch_req  in  1  fetch stage requests a read
- fetch_addr  in  ADDR_WIDTH  read address
- fetch_gnt  out  1  read issued to RAM this cycle
- fetch_valid  out  1  fetch_data valid (cycle after fetch_gnt)
- fetch_data  out  DATA_WIDTH  instruction word
- load_req  in  1  loader requests a write
- load_addr  in  ADDR_WIDTH  write address
- load_data  in  DATA_WIDTH  write data
- load_done  in  1  one-cycle pulse, loader finished initial image
- load_gnt  out  1  write issued to RAM this cycle
- cpu_hold  out  1  stall processor (high in BOOT)
- ram_en  out  1  RAM access enable
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_WIDTH  RAM address
- ram_wdata  out  DATA_WIDTH  RAM write data
- ram_rdata  in  DATA_WIDTH  RAM read data, valid cycle after read issue

## Operation
- States: BOOT, RUN. Reset -> BOOT.
- BOOT: load_req granted every cycle it is high; fetch_req never granted. cpu_hold=1.
- BOOT -> RUN on the cycle after load_done=1. A load_req in the same cycle as load_done is still granted (write lands, then RUN).
- RUN: cpu_hold=0. Only one grant per cycle.
  - fetch_req only: grant fetch. load_req only: grant load.
  - Both: grant fetch and increment starve_cnt. If starve_cnt == STARVE_LIMIT, grant load instead and clear starve_cnt.
  - starve_cnt clears whenever load is granted or load_req=0.
- load_done in RUN is ignored; there is no return to BOOT except via reset.
- RAM drive combinational from the grant: ram_en = fetch_gnt|load_gnt; ram_we = load_gnt; ram_addr/ram_wdata from the granted requester. When idle, ram_addr and ram_wdata are 0.
- Requesters hold req/addr/data stable until granted; the block does not buffer refused requests.
- fetch_data = ram_rdata passthrough, qualified by fetch_valid; value is don't-care when fetch_valid=0.

## Timing
- Grants are combinational from req, state and starve_cnt, in the same cycle.
- fetch_valid is registered: 1 exactly one cycle after fetch_gnt, otherwise 0. Back-to-back fetches give one word per cycle.
- Write is committed at the rising edge that ends the load_gnt cycle. A fetch of the same address granted next cycle returns the new data.
- Reset values: state=BOOT, cpu_hold=1, fetch_valid=0, starve_cnt=0. All grants and ram_en/ram_we are 0 while reset is asserted.
- Reset mid-operation: an in-flight fetch_valid is dropped (0 next cycle), and the block returns to BOOT.
- starve_cnt is 4 bits wide and saturates; it can never exceed STARVE_LIMIT.

## Structure
- Shared package/header: state encodings (BOOT=1'b0, RUN=1'b1) and default ADDR_WIDTH/DATA_WIDTH, reused by fetch and loader blocks.
- Sub-module: `instr_ram_prio`, the combinational two-requester priority-with-override selector (inputs: reqs and force_load; outputs: grants). Used in RUN mode.
- Top: FSM register, starve counter, fetch_valid register, RAM mux.

## Test plan
- Reset, then load_req with addr 0..5 and data 0x6C000000, 0x6840002D, ..., then load_done -> 6 load_gnt pulses, cpu_hold drops the cycle after load_done, and fetch_gnt=0 throughout BOOT.
- RUN, fetch_req continuous on addr 1 -> fetch_gnt every cycle and fetch_valid one cycle later with fetch_data=0x6840002D.
- RUN, fetch_req and load_req both held, STARVE_LIMIT=4 -> 4 fetch grants, 1 load grant, repeating; no cycle with both grants.
- Load to addr 3 with 0x90620000, then fetch addr 3 in the next cycle -> fetch_data=0x90620000.
- load_req and load_done in the same cycle in BOOT -> write performed, RUN next cycle; a later load_done in RUN has no effect.
- Assert reset the cycle after a fetch_gnt -> fetch_valid=0 and cpu_hold=1 immediately; block is in BOOT after reset release.
